// File: rtl/alu_op_sequencer_if.sv
// Command, ALU and response signals shared by alu_op_sequencer and its surroundings.
// The master modport is the sequencer side; the slave modport is the command source, ALU and consumer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [1:0]       cmd_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_sel;
    logic [WIDTH-1:0] alu_g;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [7:0]       txn_cnt;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, alu_g, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_err, txn_cnt
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, alu_g, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_err, txn_cnt
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one operation at a time to a registered ALU, waits out its latency and returns the result.
// Optional macro ALU_SELF_CHECK_EN adds a golden model that flags mismatching ALU results on rsp_err.
module alu_op_sequencer #(
    parameter int WIDTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] aluA_q, aluA_d;
    logic [WIDTH-1:0] aluB_q, aluB_d;
    logic [1:0]       aluSel_q, aluSel_d;
    logic [WIDTH-1:0] rspData_q, rspData_d;
    logic             rspValid_q, rspValid_d;
    logic             rspErr_q, rspErr_d;
    logic [7:0]       txnCnt_q, txnCnt_d;
    logic             mismatch;

`ifdef ALU_SELF_CHECK_EN
    logic [WIDTH-1:0] expected;

    always_comb begin
        expected = '0;
        case (aluSel_q)
            2'b00:   expected = aluA_q + aluB_q;
            2'b01:   expected = aluA_q - aluB_q;
            2'b10:   expected = aluA_q & aluB_q;
            default: expected = aluA_q | aluB_q;
        endcase
    end

    assign mismatch = (expected != bus.alu_g);
`else
    assign mismatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            aluA_q     <= '0;
            aluB_q     <= '0;
            aluSel_q   <= '0;
            rspData_q  <= '0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            txnCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            aluA_q     <= aluA_d;
            aluB_q     <= aluB_d;
            aluSel_q   <= aluSel_d;
            rspData_q  <= rspData_d;
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
            txnCnt_q   <= txnCnt_d;
        end
    end

    // The counter reaches zero on the edge where alu_g first reflects the latched operands.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        aluA_d     = aluA_q;
        aluB_d     = aluB_q;
        aluSel_d   = aluSel_q;
        rspData_d  = rspData_q;
        rspValid_d = rspValid_q;
        rspErr_d   = rspErr_q;
        txnCnt_d   = txnCnt_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d  = WAIT;
                    aluA_d   = bus.cmd_a;
                    aluB_d   = bus.cmd_b;
                    aluSel_d = bus.cmd_sel;
                    cnt_d    = 3'(ALU_LAT);
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d    = DONE;
                    rspData_d  = bus.alu_g;
                    rspValid_d = 1'b1;
                    rspErr_d   = mismatch;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d    = IDLE;
                    rspValid_d = 1'b0;
                    rspErr_d   = 1'b0;
                    txnCnt_d   = txnCnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.alu_a     = aluA_q;
    assign bus.alu_b     = aluB_q;
    assign bus.alu_sel   = aluSel_q;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_data  = rspData_q;
    assign bus.rsp_err   = rspErr_q;
    assign bus.txn_cnt   = txnCnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a registered ALU stand-in, a cycle-level transaction model
// checked every cycle, directed cases with literal expectations, then random traffic.
module tb_alu_op_sequencer;

   localparam int WIDTH    = 4;
   localparam int ALU_LAT  = 1;
   localparam int CLK_HALF = 5;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;
   bit   checkEn = 1'b0;
   bit   forceZero = 1'b0;
   logic [3:0] aluG = '0;

   alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

   alu_op_sequencer #(
      .WIDTH  (WIDTH),
      .ALU_LAT(ALU_LAT)
   ) dut (
      .clk  (clock),
      .reset(reset),
      .bus  (bus)
   );

   always #CLK_HALF clock = ~clock;

   function automatic logic [3:0] aluOp(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
      case (sel)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a | b;
      endcase
   endfunction

   // Registered ALU stand-in; forceZero makes it misbehave on purpose
   always @(posedge clock) aluG <= forceZero ? 4'h0 : aluOp(bus.alu_a, bus.alu_b, bus.alu_sel);
   assign bus.alu_g = aluG;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Transaction model: a command is in flight from acceptance until its response handshake,
   // and its response becomes visible ALU_LAT+1 edges after acceptance.
   bit         mBusy, mValid, mErr, mErrPend;
   logic [3:0] mA, mB, mData, mResult;
   logic [1:0] mSel;
   logic [7:0] mCnt;
   int         cyc = 0;
   int         mAcceptCyc;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mBusy  <= 1'b0;
         mValid <= 1'b0;
         mErr   <= 1'b0;
         mA     <= '0;
         mB     <= '0;
         mSel   <= '0;
         mData  <= '0;
         mCnt   <= '0;
      end else begin
         cyc <= cyc + 1;
         if (!mBusy) begin
            if (bus.cmd_valid) begin
               mBusy      <= 1'b1;
               mA         <= bus.cmd_a;
               mB         <= bus.cmd_b;
               mSel       <= bus.cmd_sel;
               mAcceptCyc <= cyc;
               mResult    <= forceZero ? 4'h0 : aluOp(bus.cmd_a, bus.cmd_b, bus.cmd_sel);
`ifdef ALU_SELF_CHECK_EN
               mErrPend   <= forceZero && (aluOp(bus.cmd_a, bus.cmd_b, bus.cmd_sel) != 4'h0);
`else
               mErrPend   <= 1'b0;
`endif
            end
         end else if (!mValid) begin
            if (cyc == mAcceptCyc + ALU_LAT + 1) begin
               mValid <= 1'b1;
               mData  <= mResult;
               mErr   <= mErrPend;
            end
         end else if (bus.rsp_ready) begin
            mValid <= 1'b0;
            mBusy  <= 1'b0;
            mErr   <= 1'b0;
            mCnt   <= mCnt + 8'd1;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clock) begin
      if (reset && checkEn) begin
         checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'(!mBusy));
         checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(mValid));
         checkOutput("rsp_data",  32'(bus.rsp_data),  32'(mData));
         checkOutput("rsp_err",   32'(bus.rsp_err),   32'(mErr));
         checkOutput("txn_cnt",   32'(bus.txn_cnt),   32'(mCnt));
         checkOutput("alu_a",     32'(bus.alu_a),     32'(mA));
         checkOutput("alu_b",     32'(bus.alu_b),     32'(mB));
         checkOutput("alu_sel",   32'(bus.alu_sel),   32'(mSel));
      end
   end

   // Presents a command at a falling edge and holds it until the rising edge that accepts it
   task automatic issueCmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
      int waitCyc = 0;
      while (!bus.cmd_ready && waitCyc < 50) begin
         @(negedge clock);
         waitCyc++;
      end
      if (!bus.cmd_ready) checkOutput("cmd_ready timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_sel   = sel;
      bus.cmd_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.cmd_valid = 1'b0;
   endtask

   // Full transaction: returns captured data, error flag and acceptance-to-valid latency in edges
   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                                input int holdLow, output logic [3:0] data, output logic err,
                                output int lat);
      bus.rsp_ready = (holdLow == 0);
      issueCmd(a, b, sel);
      lat = 0;
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
      if (!bus.rsp_valid) checkOutput("rsp_valid timeout", 32'(bus.rsp_valid), 32'd1);
      data = bus.rsp_data;
      err  = bus.rsp_err;
      if (holdLow > 0) begin
         repeat (holdLow) @(negedge clock);
         bus.rsp_ready = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      checkOutput("cmd_ready after handshake", 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] data;
      logic       err;
      int         lat;

      bus.cmd_valid = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_sel   = '0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(negedge clock);
      reset   = 1'b1;
      checkEn = 1'b1;
      @(negedge clock);
      checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset rsp_data",  32'(bus.rsp_data),  32'd0);
      checkOutput("reset txn_cnt",   32'(bus.txn_cnt),   32'd0);

      // Abort an operation mid-flight
      issueCmd(4'h4, 4'h4, 2'd0);
      #1 reset = 1'b0;
      #1;
      checkOutput("abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("abort alu_a",     32'(bus.alu_a),     32'd0);
      @(negedge clock);
      #1 reset = 1'b1;
      repeat (5) begin
         @(negedge clock);
         checkOutput("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end
      checkOutput("abort txn_cnt", 32'(bus.txn_cnt), 32'd0);

      applyStimulus(4'h9, 4'h8, 2'd0, 0, data, err, lat);
      checkOutput("add wrap data", 32'(data), 32'h1);
      checkOutput("add latency",   32'(lat),  32'd2);
      checkOutput("add txn_cnt",   32'(bus.txn_cnt), 32'd1);

      applyStimulus(4'h3, 4'h5, 2'd1, 0, data, err, lat);
      checkOutput("sub data", 32'(data), 32'hE);
      applyStimulus(4'hC, 4'hA, 2'd2, 0, data, err, lat);
      checkOutput("and data", 32'(data), 32'h8);
      applyStimulus(4'hC, 4'hA, 2'd3, 0, data, err, lat);
      checkOutput("or data", 32'(data), 32'hE);
      checkOutput("b2b txn_cnt", 32'(bus.txn_cnt), 32'd4);

      applyStimulus(4'h7, 4'h1, 2'd0, 10, data, err, lat);
      checkOutput("hold data",    32'(data),      32'h8);
      checkOutput("hold alu_a",   32'(bus.alu_a), 32'h7);
      checkOutput("hold txn_cnt", 32'(bus.txn_cnt), 32'd5);

      forceZero = 1'b1;
      applyStimulus(4'h2, 4'h2, 2'd0, 0, data, err, lat);
      forceZero = 1'b0;
      checkOutput("selfcheck data", 32'(data), 32'h0);
`ifdef ALU_SELF_CHECK_EN
      checkOutput("selfcheck err", 32'(err), 32'd1);
`else
      checkOutput("selfcheck err", 32'(err), 32'd0);
`endif

      // Random traffic, including commands offered while busy and during the response handshake
      for (int i = 0; i < 600; i++) begin
         bus.cmd_valid = ($urandom_range(0, 9) < 7);
         bus.cmd_a     = 4'($urandom);
         bus.cmd_b     = 4'($urandom);
         bus.cmd_sel   = 2'($urandom);
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      repeat (10) @(negedge clock);
      checkOutput("final idle", 32'(bus.cmd_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
